// File: rtl/scan_chain_engine.sv
// Multi-chain scan dump/restore engine: freezes the target clock, shifts NUM_CHAINS
// scan chains by a programmed count, packing captured bits out and unpacking load bits in.
module scan_chain_engine #(
  parameter int NUM_CHAINS = 4,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 20
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_start,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_W-1:0]      cfg_len,
  output logic                  busy,
  output logic                  done,
  output logic                  dut_clk_en,
  output logic                  scan_en,
  output logic                  scan_shift,
  input  logic [NUM_CHAINS-1:0] scan_out,
  output logic [NUM_CHAINS-1:0] scan_in,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  input  logic [DATA_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [2:0]            dbg_state
);

  localparam int SPW = DATA_W / NUM_CHAINS;
  localparam int CW  = $clog2(SPW + 1);
  localparam logic [CW-1:0]    SPW_C    = CW'(SPW);
  localparam logic [CW-1:0]    LAST_IDX = CW'(SPW - 1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FREEZE = 3'd1,
    S_SHIFT  = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t state, next_state;

  logic [1:0]        mode_q;       // bit0: dump, bit1: load
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] pack_reg;
  logic [CW-1:0]     pack_cnt;
  logic              pack_full;
  logic [DATA_W-1:0] unpack_reg;
  logic [CW-1:0]     unpack_cnt;

  logic              start_acc;
  logic              active;
  logic              shift_fire;
  logic              hold_free;
  logic              last_shift;
  logic              word_complete;
  logic [DATA_W-1:0] packed_next;

  assign dbg_state = state;

  // Both streams use strict valid/ready: a beat transfers on a rising edge where
  // valid and ready are both high; a raised m_tvalid holds, with m_tdata stable,
  // until that edge, and neither valid depends combinationally on its ready.

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    dut_clk_en = 1'b1;
    scan_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start && cfg_mode != 2'b00) begin
          start_acc  = 1'b1;
          next_state = (cfg_len == '0) ? S_DONE : S_FREEZE;
        end
      end
      S_FREEZE: begin
        busy       = 1'b1;
        dut_clk_en = 1'b0;
        scan_en    = 1'b1;
        next_state = S_SHIFT;
      end
      S_SHIFT: begin
        busy       = 1'b1;
        dut_clk_en = 1'b0;
        scan_en    = 1'b1;
        if (shift_fire && last_shift) next_state = S_FLUSH;
      end
      S_FLUSH: begin
        busy       = 1'b1;
        dut_clk_en = 1'b0;
        scan_en    = 1'b1;
        if (!pack_full && hold_free) next_state = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Shift gating, stream readiness and serial input selection.
  always_comb begin
    active        = (state == S_FREEZE) || (state == S_SHIFT) || (state == S_FLUSH);
    hold_free     = !m_tvalid || m_tready;
    last_shift    = (remaining == LEN_ONE);
    word_complete = (pack_cnt == LAST_IDX) || last_shift;
    shift_fire    = (state == S_SHIFT) && (remaining != '0) &&
                    (!mode_q[0] || !pack_full) &&
                    (!mode_q[1] || unpack_cnt != '0);
    s_tready      = ((state == S_FREEZE) || (state == S_SHIFT)) && mode_q[1] &&
                    (unpack_cnt == '0) && (remaining != '0);
    scan_shift    = shift_fire;
    scan_in       = '0;
    if (active) scan_in = mode_q[1] ? unpack_reg[NUM_CHAINS-1:0] : scan_out;
  end

  // Shift s within a word lands chain c at bit s*NUM_CHAINS+c; a partial word keeps zeros above.
  always_comb begin
    packed_next = pack_reg;
    for (int s = 0; s < SPW; s++) begin
      if (pack_cnt == CW'(s)) packed_next[s*NUM_CHAINS +: NUM_CHAINS] = scan_out;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mode_q     <= 2'b00;
      remaining  <= '0;
      pack_reg   <= '0;
      pack_cnt   <= '0;
      pack_full  <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      unpack_reg <= '0;
      unpack_cnt <= '0;
    end else if (start_acc) begin
      mode_q     <= cfg_mode;
      remaining  <= cfg_len;
      pack_reg   <= '0;
      pack_cnt   <= '0;
      pack_full  <= 1'b0;
      unpack_reg <= '0;
      unpack_cnt <= '0;
    end else begin
      if (shift_fire) remaining <= remaining - LEN_ONE;

      if (m_tvalid && m_tready) m_tvalid <= 1'b0;
      // A completed word goes straight to the holding register when it can;
      // otherwise it parks in the pack register and blocks further shifts.
      if (pack_full) begin
        if (hold_free) begin
          m_tdata   <= pack_reg;
          m_tvalid  <= 1'b1;
          pack_reg  <= '0;
          pack_full <= 1'b0;
        end
      end else if (shift_fire && mode_q[0]) begin
        if (word_complete) begin
          pack_cnt <= '0;
          if (hold_free) begin
            m_tdata  <= packed_next;
            m_tvalid <= 1'b1;
            pack_reg <= '0;
          end else begin
            pack_reg  <= packed_next;
            pack_full <= 1'b1;
          end
        end else begin
          pack_reg <= packed_next;
          pack_cnt <= pack_cnt + CW'(1);
        end
      end

      // The final shift drops whatever load bits are left over.
      if (s_tvalid && s_tready) begin
        unpack_reg <= s_tdata;
        unpack_cnt <= SPW_C;
      end else if (shift_fire && mode_q[1]) begin
        if (last_shift) begin
          unpack_reg <= '0;
          unpack_cnt <= '0;
        end else begin
          unpack_reg <= unpack_reg >> NUM_CHAINS;
          unpack_cnt <= unpack_cnt - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_chain_engine.sv
// Directed bench for scan_chain_engine: dump, load, swap with backpressure, and edge cases.
module tb_scan_chain_engine;

  localparam int NC = 4;
  localparam int DW = 32;
  localparam int LW = 20;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [1:0]    cfg_mode = 2'b00;
  logic [LW-1:0] cfg_len = '0;
  logic          busy, done, dut_clk_en, scan_en, scan_shift;
  logic [NC-1:0] scan_out = '0;
  logic [NC-1:0] scan_in;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [2:0]    dbg_state;

  always #5 aclk = ~aclk;

  scan_chain_engine #(.NUM_CHAINS(NC), .DATA_W(DW), .LEN_W(LW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .busy(busy), .done(done), .dut_clk_en(dut_clk_en), .scan_en(scan_en),
    .scan_shift(scan_shift), .scan_out(scan_out), .scan_in(scan_in),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] ld_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [NC-1:0] sin_q[$];
  int   n_shift, n_done, n_load, n_frozen, n_busy;
  int   done_cyc, first_shift, shifts_rel, stable_bad, mirror_bad;
  logic last_busy;

  // Drives one operation from its start cycle (cyc 0) and records what the DUT does.
  task automatic run_op(input logic [1:0] mode, input logic [LW-1:0] len,
                        input int ready_low, input bit pat, input int restart_cyc);
    logic          took, hold_prev;
    logic [DW-1:0] data_prev;
    n_shift = 0; n_done = 0; n_load = 0; n_frozen = 0; n_busy = 0;
    done_cyc = -1; first_shift = -1; shifts_rel = -1; stable_bad = 0; mirror_bad = 0;
    got_q.delete(); sin_q.delete();
    took = 1'b0; hold_prev = 1'b0; data_prev = '0; last_busy = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge aclk); #1;
      cfg_start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == 0) begin cfg_mode = mode; cfg_len = len; end
      else if (cyc == restart_cyc) begin cfg_mode = 2'b10; cfg_len = 20'd3; end
      if (took) void'(ld_q.pop_front());
      s_tvalid = (ld_q.size() != 0);
      s_tdata  = s_tvalid ? ld_q[0] : '0;
      m_tready = (cyc >= ready_low);
      scan_out = pat ? (4'(n_shift) ^ ((n_shift >= 16) ? 4'hF : 4'h0)) : 4'b0001;
      @(negedge aclk);
      took = s_tvalid && s_tready;
      if (took) n_load++;
      if (cyc == ready_low) shifts_rel = n_shift;
      if (scan_shift) begin
        if (first_shift < 0) first_shift = cyc;
        sin_q.push_back(scan_in);
        if (mode == 2'b01 && scan_in !== scan_out) mirror_bad++;
        n_shift++;
      end
      if (!dut_clk_en) n_frozen++;
      if (busy) n_busy++;
      if (hold_prev && (!m_tvalid || m_tdata !== data_prev)) stable_bad++;
      hold_prev = m_tvalid && !m_tready;
      data_prev = m_tdata;
      if (m_tvalid && m_tready) got_q.push_back(m_tdata);
      if (done) begin n_done++; if (done_cyc < 0) done_cyc = cyc; end
      last_busy = busy;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    cfg_start = 1'b0;
    s_tvalid  = 1'b0;
    ld_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%0b exp=0", done); else n_pass++;
    n_checks++; if (scan_en !== 1'b0) $display("FAIL reset_scan_en got=%0b exp=0", scan_en); else n_pass++;
    n_checks++; if (scan_shift !== 1'b0) $display("FAIL reset_scan_shift got=%0b exp=0", scan_shift); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL reset_m_tvalid got=%0b exp=0", m_tvalid); else n_pass++;
    n_checks++; if (s_tready !== 1'b0) $display("FAIL reset_s_tready got=%0b exp=0", s_tready); else n_pass++;
    n_checks++; if (dut_clk_en !== 1'b1) $display("FAIL reset_dut_clk_en got=%0b exp=1", dut_clk_en); else n_pass++;
    n_checks++; if (scan_in !== 4'h0) $display("FAIL reset_scan_in got=%h exp=0", scan_in); else n_pass++;
    n_checks++; if (m_tdata !== 32'h0) $display("FAIL reset_m_tdata got=%h exp=0", m_tdata); else n_pass++;
    aresetn = 1'b1;
  endtask

  task automatic test_dump_len8();
    logic [DW-1:0] w;
    run_op(2'b01, 20'd8, 0, 1'b0, -1);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++; if (first_shift !== 2) $display("FAIL dump8_first_shift got=%0d exp=2", first_shift); else n_pass++;
    n_checks++; if (n_shift !== 8) $display("FAIL dump8_shifts got=%0d exp=8", n_shift); else n_pass++;
    n_checks++; if (got_q.size() !== 1) $display("FAIL dump8_words got=%0d exp=1", got_q.size()); else n_pass++;
    n_checks++; if (w !== 32'h11111111) $display("FAIL dump8_word0 got=%h exp=11111111", w); else n_pass++;
    n_checks++; if (done_cyc !== 11) $display("FAIL dump8_done_cycle got=%0d exp=11", done_cyc); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL dump8_done_pulses got=%0d exp=1", n_done); else n_pass++;
    n_checks++; if (n_frozen !== 10) $display("FAIL dump8_frozen_cycles got=%0d exp=10", n_frozen); else n_pass++;
    n_checks++; if (mirror_bad !== 0) $display("FAIL dump8_recirculate got=%0d exp=0", mirror_bad); else n_pass++;
  endtask

  task automatic test_dump_len10();
    run_op(2'b01, 20'd10, 0, 1'b0, -1);
    exp_q.delete();
    exp_q.push_back(32'h11111111);
    exp_q.push_back(32'h00000011);
    n_checks++; if (got_q.size() !== 2) $display("FAIL dump10_words got=%0d exp=2", got_q.size()); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] w;
      w = (got_q.size() > i) ? got_q[i] : 'x;
      n_checks++; if (w !== exp_q[i]) $display("FAIL dump10_word%0d got=%h exp=%h", i, w, exp_q[i]); else n_pass++;
    end
    n_checks++; if (n_shift !== 10) $display("FAIL dump10_shifts got=%0d exp=10", n_shift); else n_pass++;
    n_checks++; if (done_cyc !== 13) $display("FAIL dump10_done_cycle got=%0d exp=13", done_cyc); else n_pass++;
  endtask

  task automatic test_load_len8();
    logic [NC-1:0] exp_sin[8];
    exp_sin = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4, 4'h8};
    ld_q.delete();
    ld_q.push_back(32'h84218421);
    ld_q.push_back(32'hDEADBEEF);
    run_op(2'b10, 20'd8, 0, 1'b0, -1);
    n_checks++; if (sin_q.size() !== 8) $display("FAIL load8_shifts got=%0d exp=8", sin_q.size()); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      logic [NC-1:0] v;
      v = (sin_q.size() > i) ? sin_q[i] : 'x;
      n_checks++; if (v !== exp_sin[i]) $display("FAIL load8_scan_in%0d got=%h exp=%h", i, v, exp_sin[i]); else n_pass++;
    end
    n_checks++; if (n_load !== 1) $display("FAIL load8_handshakes got=%0d exp=1", n_load); else n_pass++;
    n_checks++; if (got_q.size() !== 0) $display("FAIL load8_dump_beats got=%0d exp=0", got_q.size()); else n_pass++;
    n_checks++; if (done_cyc !== 11) $display("FAIL load8_done_cycle got=%0d exp=11", done_cyc); else n_pass++;
  endtask

  task automatic test_swap_backpressure();
    logic [DW-1:0] lw[3];
    logic [NC-1:0] exp_sin[$];
    lw = '{32'h84218421, 32'h12481248, 32'hF0F0F0F0};
    ld_q.delete();
    for (int i = 0; i < 3; i++) ld_q.push_back(lw[i]);
    ld_q.push_back(32'hDEADBEEF);
    for (int i = 0; i < 24; i++) exp_sin.push_back(lw[i/8][(i%8)*4 +: 4]);
    exp_q.delete();
    exp_q.push_back(32'h76543210);
    exp_q.push_back(32'hFEDCBA98);
    exp_q.push_back(32'h89ABCDEF);
    run_op(2'b11, 20'd24, 20, 1'b1, -1);
    n_checks++; if (shifts_rel !== 16) $display("FAIL swap_stall_shifts got=%0d exp=16", shifts_rel); else n_pass++;
    n_checks++; if (got_q.size() !== 3) $display("FAIL swap_words got=%0d exp=3", got_q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] w;
      w = (got_q.size() > i) ? got_q[i] : 'x;
      n_checks++; if (w !== exp_q[i]) $display("FAIL swap_word%0d got=%h exp=%h", i, w, exp_q[i]); else n_pass++;
    end
    n_checks++; if (n_load !== 3) $display("FAIL swap_loads got=%0d exp=3", n_load); else n_pass++;
    n_checks++; if (stable_bad !== 0) $display("FAIL swap_hold_stable got=%0d exp=0", stable_bad); else n_pass++;
    n_checks++; if (sin_q.size() !== 24) $display("FAIL swap_shifts got=%0d exp=24", sin_q.size()); else n_pass++;
    for (int i = 0; i < 24; i += 5) begin
      logic [NC-1:0] v;
      v = (sin_q.size() > i) ? sin_q[i] : 'x;
      n_checks++; if (v !== exp_sin[i]) $display("FAIL swap_scan_in%0d got=%h exp=%h", i, v, exp_sin[i]); else n_pass++;
    end
    n_checks++; if (done_cyc !== 30) $display("FAIL swap_done_cycle got=%0d exp=30", done_cyc); else n_pass++;
    n_checks++; if (n_frozen !== 29) $display("FAIL swap_frozen_cycles got=%0d exp=29", n_frozen); else n_pass++;
  endtask

  task automatic test_len_zero();
    run_op(2'b01, 20'd0, 0, 1'b0, -1);
    n_checks++; if (done_cyc !== 1) $display("FAIL len0_done_cycle got=%0d exp=1", done_cyc); else n_pass++;
    n_checks++; if (n_done !== 1) $display("FAIL len0_done_pulses got=%0d exp=1", n_done); else n_pass++;
    n_checks++; if (n_shift !== 0) $display("FAIL len0_shifts got=%0d exp=0", n_shift); else n_pass++;
    n_checks++; if (got_q.size() !== 0) $display("FAIL len0_beats got=%0d exp=0", got_q.size()); else n_pass++;
    n_checks++; if (n_busy !== 0) $display("FAIL len0_busy_cycles got=%0d exp=0", n_busy); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    ld_q.delete();
    ld_q.push_back(32'hCAFEF00D);
    run_op(2'b01, 20'd8, 0, 1'b0, 4);
    n_checks++; if (n_shift !== 8) $display("FAIL busy_start_shifts got=%0d exp=8", n_shift); else n_pass++;
    n_checks++; if (n_load !== 0) $display("FAIL busy_start_loads got=%0d exp=0", n_load); else n_pass++;
    n_checks++; if (done_cyc !== 11) $display("FAIL busy_start_done_cycle got=%0d exp=11", done_cyc); else n_pass++;
    n_checks++; if (last_busy !== 1'b0) $display("FAIL busy_start_idle_after got=%0b exp=0", last_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    logic [DW-1:0] w;
    @(posedge aclk); #1;
    cfg_mode = 2'b01; cfg_len = 20'd8; cfg_start = 1'b1; m_tready = 1'b1; scan_out = 4'b0001;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (scan_shift !== 1'b1) $display("FAIL midrst_shifting got=%0b exp=1", scan_shift); else n_pass++;
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%0b exp=0", busy); else n_pass++;
    n_checks++; if (scan_en !== 1'b0) $display("FAIL midrst_scan_en got=%0b exp=0", scan_en); else n_pass++;
    n_checks++; if (scan_shift !== 1'b0) $display("FAIL midrst_scan_shift got=%0b exp=0", scan_shift); else n_pass++;
    n_checks++; if (dut_clk_en !== 1'b1) $display("FAIL midrst_dut_clk_en got=%0b exp=1", dut_clk_en); else n_pass++;
    n_checks++; if (scan_in !== 4'h0) $display("FAIL midrst_scan_in got=%h exp=0", scan_in); else n_pass++;
    @(negedge aclk);
    aresetn = 1'b1;
    run_op(2'b01, 20'd8, 0, 1'b0, -1);
    w = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++; if (got_q.size() !== 1) $display("FAIL midrst_rerun_words got=%0d exp=1", got_q.size()); else n_pass++;
    n_checks++; if (w !== 32'h11111111) $display("FAIL midrst_rerun_word0 got=%h exp=11111111", w); else n_pass++;
    n_checks++; if (done_cyc !== 11) $display("FAIL midrst_rerun_done_cycle got=%0d exp=11", done_cyc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dump_len8();
    test_dump_len10();
    test_load_len8();
    test_swap_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
